sgmii_an_ctrl: RTL and testbench

SGMII auto-negotiation controller (Clause 37 arbitration, SGMII MAC-side profile). It runs on the 125 MHz symbol clock, after the 8b/10b decoder and ordered-set detector, and before the TX ordered-set mux. It consumes decoded /C/ config words and /I/ idle events. It decides whether TX sends config words (with or without ACK) or idles. It reports negotiated partner link, speed and duplex to entry_point's data path.

---
 rtl/sgmii_pkg.sv | 26 ++
 rtl/sgmii_an_match.sv | 63 ++++++
 rtl/sgmii_an_ctrl.sv | 116 +++++++++++
 tb/tb_sgmii_an_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sgmii_pkg.sv
// sgmii_pkg: shared states, config-word bit positions and helpers for SGMII auto-negotiation
package sgmii_pkg;
  typedef enum logic [2:0] {
    AN_ENABLE      = 3'd0,
    AN_RESTART     = 3'd1,
    ABILITY_DETECT = 3'd2,
    ACK_DETECT     = 3'd3,
    COMPLETE_ACK   = 3'd4,
    IDLE_DETECT    = 3'd5,
    LINK_OK        = 3'd6
  } an_state_t;
  localparam int CFG_LINK     = 15;
  localparam int CFG_ACK      = 14;
  localparam int CFG_DUPLEX   = 12;
  localparam int CFG_SPEED_HI = 11;
  localparam int CFG_SPEED_LO = 10;
  localparam int CFG_SGMII    = 0;
  localparam logic [15:0] CFG_ACK_MASK = 16'h4000;
  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;
  // config words compare equal when they differ at most in the ACK bit
  function automatic logic cfg_eq(input logic [15:0] a, input logic [15:0] b);
    return ((a ^ b) & ~CFG_ACK_MASK) == 16'h0000;
  endfunction
endpackage

// File: rtl/sgmii_an_match.sv
// sgmii_an_match: consecutive config/idle event counters and the ability/ack/zero/idle match flags
//   clock_i, reset_i          : symbol clock, synchronous active-high reset
//   clear_i                   : state entry, clears all counters
//   cfg_valid_i, cfg_word_i   : received /C/ event and word (wins over a coincident idle)
//   idle_valid_i              : received /I/ event
//   partner_i                 : latched partner word used by ack_match_o
//   *_match_o, word_o         : match flags and the most recent received word
module sgmii_an_match
  import sgmii_pkg::*;
#(
  parameter int MATCH_COUNT = 3
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        cfg_valid_i,
  input  logic [15:0] cfg_word_i,
  input  logic        idle_valid_i,
  input  logic [15:0] partner_i,
  output logic        ability_match_o,
  output logic        ack_match_o,
  output logic        zero_match_o,
  output logic        idle_match_o,
  output logic [15:0] word_o
);
  localparam int CW = $clog2(MATCH_COUNT + 1);
  localparam logic [CW-1:0] MC = CW'(MATCH_COUNT);
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] c);
    return c == MC ? c : c + 1'b1;
  endfunction
  logic [CW-1:0] cfg_cnt_q, cfg_cnt_d, ack_cnt_q, ack_cnt_d, zero_cnt_q, zero_cnt_d, idle_cnt_q, idle_cnt_d;
  logic [15:0] word_q, word_d;
  logic idle_ev, same_run;
  assign idle_ev  = idle_valid_i & ~cfg_valid_i;
  assign same_run = cfg_cnt_q != '0 && cfg_eq(cfg_word_i, word_q);
  always_comb begin
    cfg_cnt_d  = clear_i ? '0 : cfg_valid_i ? (same_run ? inc(cfg_cnt_q) : CW'(1)) : idle_ev ? '0 : cfg_cnt_q;
    ack_cnt_d  = clear_i ? '0 : cfg_valid_i ? (!cfg_word_i[CFG_ACK] ? '0 : same_run ? inc(ack_cnt_q) : CW'(1)) : idle_ev ? '0 : ack_cnt_q;
    zero_cnt_d = clear_i ? '0 : cfg_valid_i ? (cfg_word_i == '0 ? inc(zero_cnt_q) : '0) : idle_ev ? '0 : zero_cnt_q;
    idle_cnt_d = clear_i || cfg_valid_i ? '0 : idle_ev ? inc(idle_cnt_q) : idle_cnt_q;
    word_d     = cfg_valid_i ? cfg_word_i : word_q;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cfg_cnt_q  <= '0;
      ack_cnt_q  <= '0;
      zero_cnt_q <= '0;
      idle_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      cfg_cnt_q  <= cfg_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      word_q     <= word_d;
    end
  end
  assign ability_match_o = cfg_cnt_q == MC && (word_q & ~CFG_ACK_MASK) != '0;
  assign ack_match_o     = ability_match_o && ack_cnt_q == MC && cfg_eq(word_q, partner_i);
  assign zero_match_o    = zero_cnt_q == MC;
  assign idle_match_o    = idle_cnt_q == MC;
  assign word_o          = word_q;
endmodule

// File: rtl/sgmii_an_ctrl.sv
// sgmii_an_ctrl: SGMII MAC-side Clause 37 auto-negotiation arbitration FSM with link timer
//   clock_i, reset_i                 : 125 MHz symbol clock, synchronous active-high reset
//   an_restart_config_i              : active-low restart, holds the FSM in AN_RESTART
//   rx_sync_i                        : decoder sync, 0 forces AN_ENABLE
//   rx_config_valid_i, rx_config_i   : received /C/ event and word
//   rx_idle_valid_i                  : received /I/ event
//   tx_config_en_o, tx_config_word_o : TX ordered-set selection and config word
//   an_done_o, link_up_o, partner_*  : negotiated result, valid in LINK_OK
//   an_state_o                       : current state for debug
module sgmii_an_ctrl
  import sgmii_pkg::*;
#(
  parameter int          LINK_TIMER  = 200000,
  parameter logic [15:0] TX_ABILITY  = 16'h0001,
  parameter int          MATCH_COUNT = 3
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        an_restart_config_i,
  input  logic        rx_sync_i,
  input  logic        rx_config_valid_i,
  input  logic [15:0] rx_config_i,
  input  logic        rx_idle_valid_i,
  output logic        tx_config_en_o,
  output logic [15:0] tx_config_word_o,
  output logic        an_done_o,
  output logic        link_up_o,
  output logic [1:0]  partner_speed_o,
  output logic        partner_duplex_o,
  output logic [2:0]  an_state_o
);
  localparam int TW = $clog2(LINK_TIMER + 1);
  localparam logic [TW-1:0] T_LAST = TW'(LINK_TIMER - 1);
  an_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0] partner_q, partner_d, tx_word_q, tx_word_d, rx_word;
  logic [1:0] speed_q, speed_d;
  logic tx_en_q, tx_en_d, done_q, done_d, link_q, link_d, duplex_q, duplex_d;
  logic ability, ack, zero, idle, timer_done, entry, mismatch;
  sgmii_an_match #(.MATCH_COUNT(MATCH_COUNT)) u_match (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .clear_i        (entry),
    .cfg_valid_i    (rx_config_valid_i),
    .cfg_word_i     (rx_config_i),
    .idle_valid_i   (rx_idle_valid_i),
    .partner_i      (partner_q),
    .ability_match_o(ability),
    .ack_match_o    (ack),
    .zero_match_o   (zero),
    .idle_match_o   (idle),
    .word_o         (rx_word)
  );
  assign timer_done = timer_q == T_LAST;
  assign entry      = state_d != state_q;
  assign mismatch   = rx_config_valid_i && !cfg_eq(rx_config_i, partner_q);
  always_comb begin
    state_d = state_q;
    if (!rx_sync_i) state_d = AN_ENABLE;
    else if (!an_restart_config_i && state_q != AN_ENABLE) state_d = AN_RESTART;
    else
      case (state_q)
        AN_ENABLE:      state_d = AN_RESTART;
        AN_RESTART:     state_d = timer_done ? ABILITY_DETECT : AN_RESTART;
        ABILITY_DETECT: state_d = ability ? ACK_DETECT : ABILITY_DETECT;
        ACK_DETECT:     state_d = mismatch || zero ? AN_ENABLE : ack ? COMPLETE_ACK : ACK_DETECT;
        COMPLETE_ACK:   state_d = zero ? AN_ENABLE : timer_done ? IDLE_DETECT : COMPLETE_ACK;
        IDLE_DETECT:    state_d = ability ? AN_ENABLE : timer_done && idle ? LINK_OK : IDLE_DETECT;
        LINK_OK:        state_d = ability ? AN_ENABLE : LINK_OK;
        default:        state_d = AN_ENABLE;
      endcase
  end
  // timer is held at zero while restart is asserted so the full period runs after release;
  // it saturates so a completed period stays visible in IDLE_DETECT
  always_comb begin
    timer_d   = entry || !an_restart_config_i ? '0 : timer_done ? timer_q : timer_q + 1'b1;
    partner_d = state_q == ABILITY_DETECT && ability ? rx_word : partner_q;
    tx_en_d   = !(state_q == IDLE_DETECT || state_q == LINK_OK);
    tx_word_d = state_q == ABILITY_DETECT ? TX_ABILITY & ~CFG_ACK_MASK :
                (state_q == ACK_DETECT || state_q == COMPLETE_ACK) ? TX_ABILITY | CFG_ACK_MASK : '0;
    done_d    = state_q == LINK_OK;
    link_d    = done_d & partner_q[CFG_LINK];
    speed_d   = done_d ? partner_q[CFG_SPEED_HI:CFG_SPEED_LO] : speed_q;
    duplex_d  = done_d ? partner_q[CFG_DUPLEX] : duplex_q;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= AN_ENABLE;
      timer_q   <= '0;
      partner_q <= '0;
      tx_en_q   <= 1'b1;
      tx_word_q <= '0;
      done_q    <= 1'b0;
      link_q    <= 1'b0;
      speed_q   <= '0;
      duplex_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      partner_q <= partner_d;
      tx_en_q   <= tx_en_d;
      tx_word_q <= tx_word_d;
      done_q    <= done_d;
      link_q    <= link_d;
      speed_q   <= speed_d;
      duplex_q  <= duplex_d;
    end
  end
  assign tx_config_en_o   = tx_en_q;
  assign tx_config_word_o = tx_word_q;
  assign an_done_o        = done_q;
  assign link_up_o        = link_q;
  assign partner_speed_o  = speed_q;
  assign partner_duplex_o = duplex_q;
  assign an_state_o       = state_q;
endmodule

// File: tb/tb_sgmii_an_ctrl.sv
// tb_sgmii_an_ctrl: scoreboard bench for the SGMII auto-negotiation controller
module tb_sgmii_an_ctrl;
  import sgmii_pkg::*;
  localparam int O_STATE = 0, O_EN = 1, O_WORD = 2, O_DONE = 3, O_LINK = 4, O_SPEED = 5, O_DUP = 6;
  logic clk = 1'b0, rst = 1'b1, restart_n = 1'b0, sync = 1'b1, cfg_v = 1'b0, idle_v = 1'b0;
  logic [15:0] cfg_w = '0;
  logic tx_en, done, link, duplex;
  logic [15:0] tx_word;
  logic [1:0] speed;
  logic [2:0] an_state;
  int checks = 0, errors = 0, n;
  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];
  sgmii_an_ctrl #(.LINK_TIMER(64), .TX_ABILITY(16'h0001), .MATCH_COUNT(3)) dut (
    .clock_i            (clk),
    .reset_i            (rst),
    .an_restart_config_i(restart_n),
    .rx_sync_i          (sync),
    .rx_config_valid_i  (cfg_v),
    .rx_config_i        (cfg_w),
    .rx_idle_valid_i    (idle_v),
    .tx_config_en_o     (tx_en),
    .tx_config_word_o   (tx_word),
    .an_done_o          (done),
    .link_up_o          (link),
    .partner_speed_o    (speed),
    .partner_duplex_o   (duplex),
    .an_state_o         (an_state)
  );
  always #4 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] observe(input int sel);
    case (sel)
      O_STATE: return 16'(an_state);
      O_EN:    return 16'(tx_en);
      O_WORD:  return tx_word;
      O_DONE:  return 16'(done);
      O_LINK:  return 16'(link);
      O_SPEED: return 16'(speed);
      O_DUP:   return 16'(duplex);
      default: return 16'hxxxx;
    endcase
  endfunction
  task automatic expect_out(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic send_cfg(input logic [15:0] w, input int count);
    for (int i = 0; i < count; i++) begin
      cfg_v = 1'b1;
      cfg_w = w;
      step();
      cfg_v = 1'b0;
    end
  endtask
  task automatic send_idle(input int count);
    for (int i = 0; i < count; i++) begin
      idle_v = 1'b1;
      step();
      idle_v = 1'b0;
    end
  endtask
  task automatic wait_state(input logic [2:0] s, input int max, output int cnt);
    cnt = 0;
    while (an_state !== s && cnt < max) begin
      step();
      cnt++;
    end
    check($sformatf("reach_state_%0d", s), 16'(an_state), 16'(s));
  endtask
  task automatic negotiate_to(input logic [2:0] s);
    int c;
    send_cfg(16'hD801, 3);
    wait_state(3'd3, 10, c);
    if (s == 3'd3) return;
    send_cfg(16'hD801, 3);
    wait_state(3'd4, 10, c);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    expect_out("rst_state", O_STATE, 16'd0);
    expect_out("rst_en", O_EN, 16'd1);
    expect_out("rst_word", O_WORD, 16'h0000);
    expect_out("rst_done", O_DONE, 16'd0);
    expect_out("rst_link", O_LINK, 16'd0);
    expect_out("rst_speed", O_SPEED, 16'd0);
    expect_out("rst_dup", O_DUP, 16'd0);
    drain();
    rst = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      expect_out("hold_state", O_STATE, 16'd1);
      expect_out("hold_word", O_WORD, 16'h0000);
      drain();
      step();
    end
    restart_n = 1'b1;
    wait_state(3'd2, 200, n);
    check("restart_len", 16'(n), 16'd64);
    step();
    expect_out("ability_word", O_WORD, 16'h0001);
    expect_out("ability_en", O_EN, 16'd1);
    drain();
    send_cfg(16'hD801, 3);
    wait_state(3'd3, 10, n);
    step();
    expect_out("ack_word", O_WORD, 16'h4001);
    drain();
    send_cfg(16'hD801, 3);
    wait_state(3'd4, 10, n);
    expect_out("complete_word", O_WORD, 16'h4001);
    drain();
    wait_state(3'd5, 200, n);
    check("complete_len", 16'(n), 16'd64);
    step();
    expect_out("idle_en", O_EN, 16'd0);
    drain();
    send_idle(3);
    wait_state(3'd6, 200, n);
    step();
    expect_out("ok_done", O_DONE, 16'd1);
    expect_out("ok_link", O_LINK, 16'd1);
    expect_out("ok_speed", O_SPEED, 16'(SPEED_1000));
    expect_out("ok_dup", O_DUP, 16'd1);
    expect_out("ok_en", O_EN, 16'd0);
    drain();
    send_cfg(16'hD801, 3);
    wait_state(3'd0, 10, n);
    expect_out("prs_done_lag", O_DONE, 16'd1);
    drain();
    step();
    expect_out("prs_state", O_STATE, 16'd1);
    expect_out("prs_done", O_DONE, 16'd0);
    expect_out("prs_link", O_LINK, 16'd0);
    expect_out("prs_speed_held", O_SPEED, 16'(SPEED_1000));
    drain();
    wait_state(3'd2, 200, n);
    negotiate_to(3'd3);
    send_cfg(16'hD401, 1);
    expect_out("incons_state", O_STATE, 16'd0);
    drain();
    step();
    expect_out("incons_restart", O_STATE, 16'd1);
    expect_out("incons_done", O_DONE, 16'd0);
    drain();
    wait_state(3'd2, 200, n);
    negotiate_to(3'd4);
    repeat (5) step();
    sync = 1'b0;
    step();
    sync = 1'b1;
    expect_out("sync_state", O_STATE, 16'd0);
    drain();
    step();
    expect_out("sync_restart", O_STATE, 16'd1);
    drain();
    wait_state(3'd2, 200, n);
    check("sync_restart_len", 16'(n), 16'd64);
    negotiate_to(3'd4);
    wait_state(3'd5, 200, n);
    send_idle(2);
    cfg_v = 1'b1;
    idle_v = 1'b1;
    cfg_w = 16'hD801;
    step();
    cfg_v = 1'b0;
    idle_v = 1'b0;
    repeat (80) step();
    expect_out("coinc_no_ok", O_STATE, 16'd5);
    drain();
    send_idle(2);
    step();
    expect_out("coinc_two_idle", O_STATE, 16'd5);
    drain();
    send_idle(1);
    wait_state(3'd6, 5, n);
    rst = 1'b1;
    step();
    expect_out("mid_rst_state", O_STATE, 16'd0);
    expect_out("mid_rst_en", O_EN, 16'd1);
    expect_out("mid_rst_done", O_DONE, 16'd0);
    expect_out("mid_rst_speed", O_SPEED, 16'd0);
    drain();
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
